// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared types, port ids, defaults and helpers for the on-chip RAM arbiter.
package onchip_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int LOCK_MAX_DEF = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: one Avalon-MM master port (request side plus read return).
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_arb_rr_pick.sv
// onchip_arb_rr_pick: 2-way round-robin picker; on contention the port that did not win last goes.
module onchip_arb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o[0] = en_i & req_i[0] & (~req_i[1] | last_i);
    grant_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_i);
  end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port RAM between two Avalon-MM masters, with bounded RMW lock.
// Define ONCHIP_ARB_STATS_EN to add saturating grant/contention counters.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold_i,
  onchip_mem_arbiter_if.slave   m0,
  onchip_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     mem_address_o,
  output logic [DATA_W/8-1:0]   mem_byteenable_o,
  output logic                  mem_chipselect_o,
  output logic                  mem_write_o,
  output logic [DATA_W-1:0]     mem_writedata_o,
  output logic                  mem_clken_o,
  input  logic [DATA_W-1:0]     mem_readdata_i
`ifdef ONCHIP_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grant0_o,
  output logic [31:0]           stat_grant1_o,
  output logic [31:0]           stat_contend_o
`endif
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX);
  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] blk_q, blk_d;
  logic last_q, last_d, rd_pend_q, rd_pend_d, rd_port_q, rd_port_d;
  logic [1:0] req, req_m, lck, grant;
  logic own, in_lock, held, forced, pick_last, port, gnt, can_lock;
  // Lock ends combinationally: the cycle the owner drops lock or hits LOCK_MAX is already arbitrated as IDLE.
  always_comb begin
    req = {m1.read | m1.write, m0.read | m0.write};
    lck = {m1.lock, m0.lock};
    own = state_q == LOCK1;
    in_lock = (state_q != IDLE) & lck[own];
    held = in_lock & (cnt_q != CMAX);
    forced = in_lock & (cnt_q == CMAX);
    req_m = held ? req & (own ? 2'b10 : 2'b01) : req;
    pick_last = forced ? own : last_q;
  end
  onchip_arb_rr_pick u_pick (
    .req_i   (req_m),
    .last_i  (pick_last),
    .en_i    (~hold_i),
    .grant_o (grant)
  );
  always_comb begin
    port = grant[1];
    gnt = |grant;
    mem_chipselect_o = gnt;
    mem_address_o = !gnt ? '0 : port ? m1.address : m0.address;
    mem_byteenable_o = !gnt ? '0 : port ? m1.byteenable : m0.byteenable;
    mem_writedata_o = !gnt ? '0 : port ? m1.writedata : m0.writedata;
    mem_write_o = gnt & (port ? m1.write : m0.write);
    mem_clken_o = ~(hold_i & ~rd_pend_q);
    m0.waitrequest = req[0] & ~grant[0];
    m1.waitrequest = req[1] & ~grant[1];
    m0.readdata = mem_readdata_i;
    m1.readdata = mem_readdata_i;
    m0.readdatavalid = rd_pend_q & (rd_port_q == PORT_M0);
    m1.readdatavalid = rd_pend_q & (rd_port_q == PORT_M1);
    blk_d = (blk_q & lck) | (forced ? (own ? 2'b10 : 2'b01) : 2'b00);
    can_lock = gnt & lck[port] & ~blk_q[port] & ~(forced & (own == port));
    last_d = gnt ? port : pick_last;
    rd_pend_d = gnt & (port ? m1.read & ~m1.write : m0.read & ~m0.write);
    rd_port_d = port;
    state_d = held ? state_q : can_lock ? (port ? LOCK1 : LOCK0) : IDLE;
    cnt_d = held ? cnt_q + {{(CW-1){1'b0}}, !hold_i} : can_lock ? CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      blk_q <= '0;
      last_q <= PORT_M1;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_M0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      last_q <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end
`ifdef ONCHIP_ARB_STATS_EN
  logic [31:0] sg0_q, sg1_q, sc_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sg0_q <= '0;
      sg1_q <= '0;
      sc_q <= '0;
    end else begin
      sg0_q <= sat_inc(sg0_q, grant[0]);
      sg1_q <= sat_inc(sg1_q, grant[1]);
      sc_q <= sat_inc(sc_q, &req);
    end
  end
  assign stat_grant0_o = sg0_q;
  assign stat_grant1_o = sg1_q;
  assign stat_contend_o = sc_q;
`endif
endmodule
